run_scheduler: RTL

RUN_SCHEDULER -- requirements
Module: run_scheduler

---
 rtl/run_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/run_scheduler.sv
// Run sequencer for the annealing node array: OPT -> EXP -> EXCH phases per iteration.
// Optional busy-cycle statistics counter enabled by defining RUN_SCHED_STATS_EN.
module run_scheduler #(
  parameter int unsigned EXP_CYCLES  = 17,
  parameter int unsigned EXCH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_write,
  input  logic [23:0] run_times,
  input  logic        abort,
  input  logic        opt_done,
  output logic        running,
  output logic        opt_run,
  output logic        exp_init,
  output logic        exp_run,
  output logic        exp_fin,
  output logic        exch_run,
  output logic        exch_odd,
  output logic [23:0] iter_left,
  output logic        done,
  output logic [31:0] busy_cycles
);

  typedef enum logic [3:0] {
    IDLE,
    OPT,
    WAIT_OPT,
    EXP_INIT,
    EXP_RUN,
    EXP_FIN,
    EXCH,
    EXCH_WAIT,
    NEXT
  } state_t;

  localparam logic [7:0] EXP_LOAD  = 8'(EXP_CYCLES - 1);
  localparam logic [7:0] EXCH_LOAD = 8'(EXCH_CYCLES - 1);

  state_t     state, next_state;
  logic [7:0] phase_cnt;
  logic       opt_seen;
  logic       start_ok, zero_ok, last_iter;

  assign start_ok  = (state == IDLE) && run_write && !abort && (run_times != '0);
  assign zero_ok   = (state == IDLE) && run_write && !abort && (run_times == '0);
  assign last_iter = (state == NEXT) && !abort && (iter_left == 24'd1);

  always_comb begin
    next_state = state;
    if (state != IDLE && abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:      if (start_ok) next_state = OPT;
        OPT:       next_state = WAIT_OPT;
        WAIT_OPT:  if (opt_seen) next_state = EXP_INIT;
        EXP_INIT:  next_state = EXP_RUN;
        EXP_RUN:   if (phase_cnt == '0) next_state = EXP_FIN;
        EXP_FIN:   next_state = EXCH;
        EXCH:      next_state = EXCH_WAIT;
        EXCH_WAIT: if (phase_cnt == '0) next_state = NEXT;
        NEXT:      next_state = (iter_left == 24'd1) ? IDLE : OPT;
        default:   next_state = IDLE;
      endcase
    end
  end

  // Outputs are flops decoded from next_state so each lines up with its state
  // while staying registered. opt_done is captured only in WAIT_OPT and acted
  // on one cycle later, keeping it off any output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      running   <= 1'b0;
      opt_run   <= 1'b0;
      exp_init  <= 1'b0;
      exp_run   <= 1'b0;
      exp_fin   <= 1'b0;
      exch_run  <= 1'b0;
      exch_odd  <= 1'b0;
      done      <= 1'b0;
      iter_left <= '0;
      phase_cnt <= '0;
      opt_seen  <= 1'b0;
    end else begin
      state    <= next_state;
      running  <= (next_state != IDLE);
      opt_run  <= (next_state == OPT);
      exp_init <= (next_state == EXP_INIT);
      exp_run  <= (next_state == EXP_RUN);
      exp_fin  <= (next_state == EXP_FIN);
      exch_run <= (next_state == EXCH);
      done     <= zero_ok || last_iter;
      opt_seen <= (state == WAIT_OPT) && opt_done;

      if (state == EXP_INIT) begin
        phase_cnt <= EXP_LOAD;
      end else if (state == EXCH) begin
        phase_cnt <= EXCH_LOAD;
      end else if (phase_cnt != '0) begin
        phase_cnt <= phase_cnt - 8'd1;
      end

      if (start_ok) begin
        iter_left <= run_times;
        exch_odd  <= 1'b0;
      end else if (state == NEXT && !abort) begin
        iter_left <= iter_left - 24'd1;
        exch_odd  <= ~exch_odd;
      end
    end
  end

`ifdef RUN_SCHED_STATS_EN
  logic [31:0] busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else if (start_ok) begin
      busy_q <= '0;
    end else if (running && busy_q != '1) begin
      busy_q <= busy_q + 32'd1;
    end
  end

  assign busy_cycles = busy_q;
`else
  assign busy_cycles = '0;
`endif

endmodule
